vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 102 ++++++++++
 tb/tb_vga_timing_gen.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/blank/colour timing generator with built-in test patterns
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int SYNC_POL = 0,
  parameter int COLOR_W  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         pattern_sel,
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
  output logic [10:0]        pixel_x,
  output logic [10:0]        pixel_y,
  output logic [COLOR_W-1:0] RED,
  output logic [COLOR_W-1:0] GREEN,
  output logic [COLOR_W-1:0] BLUE,
  output logic               hSync,
  output logic               vSync,
  output logic               vga_blank,
  output logic               vga_clock,
  output logic               frame_start,
  output logic               line_start
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_ON    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_OFF   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_ON    = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_OFF   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] BAR_W    = 11'(H_ACTIVE / 8);
  localparam logic [10:0] BARS_END = 11'(8 * (H_ACTIVE / 8));
  localparam logic SP = SYNC_POL != 0;
  localparam int RGB_W = 3 * COLOR_W;
  logic [DW-1:0] div_cnt, div_d;
  logic [10:0] h_cnt, v_cnt, h_d, v_d;
  logic [2:0] bar_idx;
  logic tick, active, bar_on, vclk_d, fs_d, ls_d, blank_d, hs_d, vs_d;
  logic [RGB_W-1:0] bar_rgb, pat_rgb, rgb_d;
  assign pixel_x = h_cnt;
  assign pixel_y = v_cnt;
  assign tick    = div_cnt == DIV_LAST;
  assign active  = h_cnt < H_ACT && v_cnt < V_ACT;
  assign bar_on  = h_cnt < BARS_END;
  assign bar_idx = 3'(h_cnt / BAR_W);
  // Next-state for counters and one-tick-delayed video outputs; enable low clears everything
  always_comb begin
    bar_rgb = {{COLOR_W{bar_on & ~bar_idx[1]}}, {COLOR_W{bar_on & ~bar_idx[2]}}, {COLOR_W{bar_on & ~bar_idx[0]}}};
    pat_rgb = pattern_sel == 2'd0 ? {pix_r, pix_g, pix_b} :
              pattern_sel == 2'd1 ? {{COLOR_W{1'b1}}, {2*COLOR_W{1'b0}}} :
              pattern_sel == 2'd2 ? bar_rgb : {RGB_W{h_cnt[5] ^ v_cnt[5]}};
    div_d   = !enable || tick ? '0 : div_cnt + 1'b1;
    h_d     = !enable ? '0 : !tick ? h_cnt : h_cnt == H_LAST ? '0 : h_cnt + 1'b1;
    v_d     = !enable ? '0 : !tick || h_cnt != H_LAST ? v_cnt : v_cnt == V_LAST ? '0 : v_cnt + 1'b1;
    vclk_d  = div_d >= DIV_HALF;
    fs_d    = enable && tick && h_cnt == '0 && v_cnt == '0;
    ls_d    = enable && tick && h_cnt == '0;
    rgb_d   = !enable ? '0 : tick ? (active ? pat_rgb : '0) : {RED, GREEN, BLUE};
    blank_d = enable && (tick ? active : vga_blank);
    hs_d    = !enable ? ~SP : tick ? (h_cnt >= HS_ON && h_cnt < HS_OFF ? SP : ~SP) : hSync;
    vs_d    = !enable ? ~SP : tick ? (v_cnt >= VS_ON && v_cnt < VS_OFF ? SP : ~SP) : vSync;
  end
  // State and output registers with asynchronous reset
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      div_cnt            <= '0;
      h_cnt              <= '0;
      v_cnt              <= '0;
      vga_clock          <= 1'b0;
      frame_start        <= 1'b0;
      line_start         <= 1'b0;
      {RED, GREEN, BLUE} <= '0;
      vga_blank          <= 1'b0;
      hSync              <= ~SP;
      vSync              <= ~SP;
    end else begin
      div_cnt            <= div_d;
      h_cnt              <= h_d;
      v_cnt              <= v_d;
      vga_clock          <= vclk_d;
      frame_start        <= fs_d;
      line_start         <= ls_d;
      {RED, GREEN, BLUE} <= rgb_d;
      vga_blank          <= blank_d;
      hSync              <= hs_d;
      vSync              <= vs_d;
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized check of vga_timing_gen against a clock-count arithmetic model
module tb_vga_timing_gen;
  localparam int HA = 640, HFP = 16, HS = 96, HB = 48;
  localparam int VA = 6, VFP = 1, VS = 2, VB = 1;
  localparam int D = 2, CW = 8;
  localparam int HT = HA + HFP + HS + HB, VT = VA + VFP + VS + VB;
  logic clock = 0, reset = 1, enable = 1;
  logic [1:0] pattern_sel = 2'd2;
  logic [CW-1:0] pix_r = 0, pix_g = 0, pix_b = 0;
  logic [10:0] pixel_x, pixel_y;
  logic [CW-1:0] RED, GREEN, BLUE;
  logic hSync, vSync, vga_blank, vga_clock, frame_start, line_start;
  int checks = 0, errors = 0;
  int k = 0, q, h, v;
  logic [23:0] e_rgb = 0;
  logic e_blank = 0, e_hs = 1, e_vs = 1, e_fs = 0, e_ls = 0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(D), .SYNC_POL(0), .COLOR_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
    .hSync(hSync), .vSync(vSync), .vga_blank(vga_blank), .vga_clock(vga_clock),
    .frame_start(frame_start), .line_start(line_start)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] colour(input int hh, input int vv, input logic [1:0] p, input logic [23:0] px);
    case (p)
      2'd0:    return px;
      2'd1:    return 24'hFF0000;
      2'd2:    return hh < 8 * (HA / 8) ? bars[hh / (HA / 8)] : 24'h0;
      default: return ((hh / 32 + vv / 32) % 2) != 0 ? 24'hFFFFFF : 24'h0;
    endcase
  endfunction

  // Model: k counts enabled clocks since restart; pixel position and outputs follow by arithmetic
  always @(posedge clock or posedge reset) begin
    if (reset || !enable) begin
      k = 0; e_rgb = 0; e_blank = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_ls = 0;
    end else begin
      e_fs = 0; e_ls = 0;
      if (k % D == D - 1) begin
        q = k / D; h = q % HT; v = (q / HT) % VT;
        e_blank = h < HA && v < VA;
        e_rgb   = e_blank ? colour(h, v, pattern_sel, {pix_r, pix_g, pix_b}) : 24'h0;
        e_hs    = !(h >= HA + HFP && h < HA + HFP + HS);
        e_vs    = !(v >= VA + VFP && v < VA + VFP + VS);
        e_fs    = h == 0 && v == 0;
        e_ls    = h == 0;
      end
      k++;
    end
  end

  // Compare every DUT output to the model on the falling edge
  always @(negedge clock) begin
    chk("pixel_x", 32'(pixel_x), 32'((k / D) % HT));
    chk("pixel_y", 32'(pixel_y), 32'((k / D / HT) % VT));
    chk("vga_clock", 32'(vga_clock), 32'((k % D) >= D / 2));
    chk("rgb", 32'({RED, GREEN, BLUE}), 32'(e_rgb));
    chk("vga_blank", 32'(vga_blank), 32'(e_blank));
    chk("hSync", 32'(hSync), 32'(e_hs));
    chk("vSync", 32'(vSync), 32'(e_vs));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("line_start", 32'(line_start), 32'(e_ls));
  end

  task automatic random_run(input int n);
    repeat (n) begin
      @(negedge clock);
      pix_r = 8'($urandom); pix_g = 8'($urandom); pix_b = 8'($urandom);
      if ($urandom_range(0, 299) == 0) pattern_sel = 2'($urandom);
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 0;
    for (int n = 1; n <= 1510; n++) begin
      @(posedge clock); #1;
      if (n == 2) begin
        chk("lit_fs_first", 32'(frame_start), 32'd1);
        chk("lit_ls_first", 32'(line_start), 32'd1);
        chk("lit_rgb_h0", 32'({RED, GREEN, BLUE}), 32'hFFFFFF);
        chk("lit_px_first", 32'(pixel_x), 32'd1);
        chk("lit_vclk_fall", 32'(vga_clock), 32'd0);
      end
      if (n == 3) begin
        chk("lit_fs_pulse", 32'(frame_start), 32'd0);
        chk("lit_vclk_rise", 32'(vga_clock), 32'd1);
      end
      if (n == 162) chk("lit_rgb_h80", 32'({RED, GREEN, BLUE}), 32'hFFFF00);
      if (n == 1280) begin
        chk("lit_rgb_h639", 32'({RED, GREEN, BLUE}), 32'h0);
        chk("lit_blank_h639", 32'(vga_blank), 32'd1);
      end
      if (n == 1282) begin
        chk("lit_blank_h640", 32'(vga_blank), 32'd0);
        chk("lit_rgb_h640", 32'({RED, GREEN, BLUE}), 32'h0);
      end
      if (n == 1312) chk("lit_hs_h655", 32'(hSync), 32'd1);
      if (n == 1314) chk("lit_hs_h656", 32'(hSync), 32'd0);
      if (n == 1504) chk("lit_hs_h751", 32'(hSync), 32'd0);
      if (n == 1506) chk("lit_hs_h752", 32'(hSync), 32'd1);
    end
    random_run(20000);
    @(negedge clock); enable = 0;
    @(posedge clock); #1;
    chk("lit_idle_blank", 32'(vga_blank), 32'd0);
    chk("lit_idle_px", 32'(pixel_x), 32'd0);
    chk("lit_idle_hs", 32'(hSync), 32'd1);
    repeat (9) @(negedge clock);
    enable = 1;
    @(posedge clock); #1;
    chk("lit_en_px0", 32'(pixel_x), 32'd0);
    chk("lit_en_fs0", 32'(frame_start), 32'd0);
    @(posedge clock); #1;
    chk("lit_en_fs1", 32'(frame_start), 32'd1);
    random_run(3000);
    pattern_sel = 2'd1;
    @(posedge clock); #3 reset = 1; #1;
    chk("lit_rst_rgb", 32'({RED, GREEN, BLUE}), 32'h0);
    chk("lit_rst_px", 32'(pixel_x), 32'd0);
    chk("lit_rst_blank", 32'(vga_blank), 32'd0);
    chk("lit_rst_hs", 32'(hSync), 32'd1);
    chk("lit_rst_vs", 32'(vSync), 32'd1);
    chk("lit_rst_vclk", 32'(vga_clock), 32'd0);
    @(negedge clock); reset = 0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("lit_rst_fs", 32'(frame_start), 32'd1);
    chk("lit_red_solid", 32'({RED, GREEN, BLUE}), 32'hFF0000);
    random_run(18000);
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
